// File: rtl/bus_ram_target.sv
// Bus target backed by word-addressed on-chip RAM with WAIT_CYCLES wait states before each access.
// Define BUS_RAM_TARGET_STATS_EN to add read/write/stall counter outputs.
module bus_ram_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h10000000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_range_error
`ifdef BUS_RAM_TARGET_STATS_EN
    ,
    output logic [31:0] o_read_count,
    output logic [31:0] o_write_count,
    output logic [31:0] o_stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam int         WORDS     = 2 ** ADDR_BITS;

    state_t        state_reg;
    logic [3:0]    wait_cnt_reg;
    logic          rw_reg;
    logic [31:2]   addr_reg;
    logic [31:0]   wdata_reg;

    logic [31:0]   mem [0:WORDS-1];

    logic [29:0]          word_off;
    logic                 in_range;
    logic [ADDR_BITS-1:0] word_index;
    logic                 mem_we;
    logic                 unused_addr_bits;

    // Byte-address range test done on word addresses; the subtraction wraps, so
    // addresses below the base land far outside and never alias into the RAM.
    assign word_off   = addr_reg - BASE_ADDR[31:2];
    assign in_range   = (addr_reg >= BASE_ADDR[31:2]) && (word_off[29:ADDR_BITS] == '0);
    assign word_index = word_off[ADDR_BITS-1:0];
    assign mem_we     = (state_reg == S_ACCESS) && rw_reg && in_range;

    assign unused_addr_bits = &{1'b0, i_address[1:0]};

    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem[word_index] <= wdata_reg;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= 4'd0;
            rw_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            o_ready       <= 1'b0;
            o_rdata       <= 32'd0;
            o_range_error <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_request) begin
                        rw_reg       <= i_rw;
                        addr_reg     <= i_address[31:2];
                        wdata_reg    <= i_wdata;
                        wait_cnt_reg <= WAIT_LOAD;
                        state_reg    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= S_ACCESS;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (in_range) begin
                        if (!rw_reg) begin
                            o_rdata <= mem[word_index];
                        end
                    end else begin
                        o_rdata       <= 32'd0;
                        o_range_error <= 1'b1;
                    end
                    o_ready   <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    // A request dropped early still lands here, giving a one-cycle ready pulse.
                    if (!i_request) begin
                        o_ready   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    o_ready   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_RAM_TARGET_STATS_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_read_count  <= 32'd0;
            o_write_count <= 32'd0;
            o_stall_count <= 32'd0;
        end else begin
            if (state_reg == S_ACCESS) begin
                if (rw_reg) begin
                    o_write_count <= o_write_count + 32'd1;
                end else begin
                    o_read_count <= o_read_count + 32'd1;
                end
            end
            if (i_request && !o_ready) begin
                o_stall_count <= o_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_ram_target.sv
// Scoreboard bench for bus_ram_target: three instances with 0, 3 and 2 wait states
// driven one at a time from directed vectors; a negedge monitor checks each ready rise.
module tb_bus_ram_target;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n;
    logic [NI-1:0] req;
    logic [NI-1:0] rw;
    logic [NI-1:0] ready;
    logic [NI-1:0] rerr;
    logic [31:0]   addr  [NI];
    logic [31:0]   wdata [NI];
    logic [31:0]   rdata [NI];
`ifdef BUS_RAM_TARGET_STATS_EN
    logic [31:0]   rcnt  [NI];
    logic [31:0]   wcnt  [NI];
    logic [31:0]   scnt  [NI];
`endif

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        bus_ram_target #(
            .BASE_ADDR  (32'h10000000),
            .ADDR_BITS  (10),
            .WAIT_CYCLES((gi == 0) ? 0 : ((gi == 1) ? 3 : 2))
        ) u_dut (
            .i_clock      (clk),
            .i_reset      (rst_n[gi]),
            .i_request    (req[gi]),
            .i_rw         (rw[gi]),
            .i_address    (addr[gi]),
            .i_wdata      (wdata[gi]),
            .o_ready      (ready[gi]),
            .o_rdata      (rdata[gi]),
            .o_range_error(rerr[gi])
`ifdef BUS_RAM_TARGET_STATS_EN
            ,
            .o_read_count (rcnt[gi]),
            .o_write_count(wcnt[gi]),
            .o_stall_count(scnt[gi])
`endif
        );
    end

    typedef struct {
        int          k;
        int          exp_cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        int          k;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          hold;
        logic        mutate;
        logic        drop;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic void check(input string name, input int k,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endfunction

    function automatic vec_t mk(input int k, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] rd,
                                input logic err, input int hold,
                                input logic mutate, input logic drop);
        vec_t v;
        v.k = k; v.rw = w; v.addr = a; v.wdata = d; v.rd = rd;
        v.err = err; v.hold = hold; v.mutate = mutate; v.drop = drop;
        return v;
    endfunction

    // Monitor: pops one expectation per rising edge of ready.
    logic [NI-1:0] prev_ready = '0;
    exp_t          mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst_n[k] && ready[k] && !prev_ready[k]) begin
                if (sbq.size() == 0 || sbq[0].k != k) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready dut%0d: got ready=1 expected no transaction", k);
                end else begin
                    mon_e = sbq.pop_front();
                    check("latency", k, cyc, mon_e.exp_cyc);
                    check("rdata", k, rdata[k], mon_e.rd);
                    check("range_error", k, {31'd0, rerr[k]}, {31'd0, mon_e.err});
                    $display("dut%0d done: cycle=%0d rdata=%h range_error=%0d",
                             k, cyc, rdata[k], rerr[k]);
                end
            end
        end
        prev_ready <= ready;
    end

    task automatic run_vec(input vec_t v);
        int   k;
        exp_t e;
        bit   seen;
        k = v.k;
        @(posedge clk);
        #1;
        req[k]   = 1'b1;
        rw[k]    = v.rw;
        addr[k]  = v.addr;
        wdata[k] = v.wdata;
        e.k       = k;
        e.exp_cyc = cyc + wait_of(k) + 2;
        e.rd      = v.rd;
        e.err     = v.err;
        sbq.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (i == 0 && v.mutate) begin
                addr[k]  = v.addr + 32'd4;
                wdata[k] = ~v.wdata;
            end
            if (i == 0 && v.drop) req[k] = 1'b0;
            if (ready[k]) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout dut%0d: got ready=0 expected ready within 40 cycles", k);
            req[k] = 1'b0;
            sbq.delete();
            return;
        end
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check("ready_held", k, {31'd0, ready[k]}, 32'd1);
            check("rdata_stable", k, rdata[k], v.rd);
        end
        req[k] = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", k, {31'd0, ready[k]}, 32'd0);
        check("rdata_keep", k, rdata[k], v.rd);
        check("range_sticky", k, {31'd0, rerr[k]}, {31'd0, v.err});
    endtask

    initial begin
        rst_n = '0;
        req   = '0;
        rw    = '0;
        for (int k = 0; k < NI; k++) begin
            addr[k]  = 32'd0;
            wdata[k] = 32'd0;
        end

        // k, rw, addr, wdata, expected rdata, expected range_error, hold, mutate, drop
        vecs.push_back(mk(0, 1, 32'h10000010, 32'hDEADBEEF, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10000010, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h10000000, 32'h12345678, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10000000, 32'h0,        32'h12345678, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10000013, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h10000FFC, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10000FFC, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0FFFFFFC, 32'h0,        32'h00000000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h10001000, 32'hAAAA5555, 32'h00000000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 32'h77777777, 32'h00000000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10000000, 32'h0,        32'h12345678, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h10000010, 32'h0,        32'hDEADBEEF, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h10000000, 32'h0BADF00D, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h10000000, 32'h0,        32'h0BADF00D, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, 32'h1000000C, 32'h55556666, 32'h0BADF00D, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h10000008, 32'h11112222, 32'h0BADF00D, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h10000008, 32'h0,        32'h11112222, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h1000000C, 32'h0,        32'h55556666, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h10000000, 32'h0,        32'h0BADF00D, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h10000008, 32'h0,        32'h11112222, 0, 0, 0, 0));
        vecs.push_back(mk(2, 1, 32'h10000004, 32'h00000001, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(2, 1, 32'h10000008, 32'h00000002, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h10000004, 32'h0,        32'h00000001, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h10000008, 32'h0,        32'h00000002, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h10000004, 32'h0,        32'h00000001, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("reset_ready", k, {31'd0, ready[k]}, 32'd0);
            check("reset_rdata", k, rdata[k], 32'd0);
            check("reset_range_error", k, {31'd0, rerr[k]}, 32'd0);
`ifdef BUS_RAM_TARGET_STATS_EN
            check("reset_read_count", k, rcnt[k], 32'd0);
            check("reset_write_count", k, wcnt[k], 32'd0);
            check("reset_stall_count", k, scnt[k], 32'd0);
`endif
        end
        rst_n = '1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort a write in its wait phase; outputs must clear without waiting for a clock.
        @(posedge clk);
        #1;
        req[1]   = 1'b1;
        rw[1]    = 1'b1;
        addr[1]  = 32'h10000008;
        wdata[1] = 32'hDEADDEAD;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        #1;
        check("abort_ready", 1, {31'd0, ready[1]}, 32'd0);
        check("abort_rdata", 1, rdata[1], 32'd0);
        req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        run_vec(mk(1, 0, 32'h10000008, 32'h0, 32'h11112222, 0, 0, 0, 0));

`ifdef BUS_RAM_TARGET_STATS_EN
        check("read_count", 2, rcnt[2], 32'd3);
        check("write_count", 2, wcnt[2], 32'd2);
        check("stall_count", 2, scnt[2], 32'd20);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 0, sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
